irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of interrupt sources (legal range 2..16).
REQ-002 Parameter DATA_W, default 32, SHALL set the width of the source payload.
REQ-003 Parameter EDGE_MASK, default all ones (NUM_SRC bits), SHALL select per source: 1 = rising-edge triggered, 0 = level triggered.
REQ-004 Parameter MASK_RST, default all ones (NUM_SRC bits), SHALL be the mask register value at reset.
REQ-005 Local ID_W SHALL equal $clog2(NUM_SRC).
REQ-006 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- irq_src, input, NUM_SRC: interrupt lines, synchronous to clk.
- src_data, input, NUM_SRC*DATA_W: per-source payload, packed with source i at bits [i*DATA_W +: DATA_W].
- mask_we, input, 1: mask write strobe.
- mask_wdata, input, NUM_SRC: new mask value; 1 = enabled.
- irq_ack, input, 1: processor accepts the request.
- irq_done, input, 1: processor has finished the handler.
- irq_req, output, 1: interrupt request to the processor.
- irq_id, output, ID_W: winning source index.
- irq_data, output, DATA_W: captured payload of the winning source.
- pending, output, NUM_SRC: pending register.
- busy, output, 1: high while the FSM is in REQ or SERVICE.

Function
REQ-008 An edge source SHALL set pending[i] the cycle after irq_src[i] goes 0->1; a level source SHALL set it every cycle irq_src[i] is high.
REQ-009 src_data[i] SHALL be captured into hold register i on the same edge that sets pending[i] from 0; while pending[i] is already 1, the hold register SHALL not be overwritten.
REQ-010 Masked sources SHALL still set pending but SHALL NOT be eligible for arbitration.
REQ-011 The FSM SHALL have three states: IDLE, REQ, SERVICE.
REQ-012 IDLE: if (pending & mask) is nonzero, the FSM SHALL register the winner into irq_id and its hold register into irq_data, then go to REQ.
REQ-013 REQ: irq_req SHALL be 1, with irq_id and irq_data held stable; on irq_ack, pending[irq_id] SHALL be cleared on that edge and the FSM SHALL go to SERVICE.
REQ-014 SERVICE: irq_req SHALL be 0; on irq_done the FSM SHALL go to IDLE. At least one IDLE cycle SHALL occur between services.
REQ-015 irq_ack outside REQ and irq_done outside SERVICE SHALL be ignored.
REQ-016 If a set and a clear of the same pending bit occur in the same cycle, the set SHALL win and the hold register SHALL recapture.
REQ-017 A mask write during REQ or SERVICE SHALL NOT withdraw the committed request; it SHALL take effect at the next arbitration.
REQ-018 Latency: an edge sampled at cycle N SHALL give pending at N+1 and irq_req at N+2, provided the FSM is IDLE.

Reset
REQ-019 rst_n low SHALL asynchronously force: pending = 0, edge history = 0, hold registers = 0, mask = MASK_RST, state = IDLE, irq_req = 0, irq_id = 0, irq_data = 0, busy = 0.
REQ-020 Reset asserted mid-REQ or mid-SERVICE SHALL drop irq_req immediately and discard all pending events.

Configuration
REQ-021 With IRQ_RR_EN defined, arbitration SHALL be round-robin: search starts at the index one above the last-acked id, wrapping from NUM_SRC-1 to 0, with last-acked = NUM_SRC-1 at reset.
REQ-022 Without IRQ_RR_EN, arbitration SHALL be fixed priority, lowest index wins.

Structure
REQ-023 Package irq_pkg SHALL hold the FSM state enum (IDLE/REQ/SERVICE) and the maximum-source constant (16).
REQ-024 Arbitration SHALL be a combinational sub-module irq_arb (inputs: request vector, last id; outputs: valid, winner id), instantiated once.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Edge pulse on src 2 with data 32'hDEADBEEF -> irq_req 2 cycles later, irq_id = 2, irq_data = 32'hDEADBEEF; ack clears pending[2].
- Srcs 1 and 3 simultaneous, fixed priority -> id 1 serviced, then id 3 after done plus one IDLE cycle.
- With IRQ_RR_EN, all 4 sources held pending continuously -> service order 0, 1, 2, 3, 0.
- Src 0 masked, then pulsed -> no irq_req, pending[0] = 1; unmask -> irq_req with the original captured data.
- New edge on src 2 in the cycle it is acked -> pending[2] stays 1 with new data; a second service of id 2 follows.
- rst_n low during REQ -> irq_req = 0 and pending = 0 immediately; no request after release with inputs low.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared FSM state type and source-count limit for the interrupt controller.
package irq_pkg;

  localparam int MAX_SRC = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the interrupt controller (slave) and its environment /
// processor side (master), plus a debug view of the request FSM state.
interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_SRC);

  // Handshake: irq_req stays high with irq_id/irq_data stable until the cycle
  // irq_ack is sampled high; irq_done then ends the service. irq_ack is only
  // honoured while irq_req is high, irq_done only while servicing.
  logic [NUM_SRC-1:0]        irq_src;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      mask_we;
  logic [NUM_SRC-1:0]        mask_wdata;
  logic                      irq_ack;
  logic                      irq_done;
  logic                      irq_req;
  logic [ID_W-1:0]           irq_id;
  logic [DATA_W-1:0]         irq_data;
  logic [NUM_SRC-1:0]        pending;
  logic                      busy;
  state_t                    dbg_state;

  modport master (
    output irq_src, src_data, mask_we, mask_wdata, irq_ack, irq_done,
    input  irq_req, irq_id, irq_data, pending, busy, dbg_state
  );

  modport slave (
    input  irq_src, src_data, mask_we, mask_wdata, irq_ack, irq_done,
    output irq_req, irq_id, irq_data, pending, busy, dbg_state
  );

endinterface

// File: rtl/irq_arb.sv
// Combinational arbiter: lowest index wins by default; with IRQ_RR_EN the
// search starts one above last_id_i and wraps.
module irq_arb
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    last_id_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

`ifdef IRQ_RR_EN
  logic [ID_W-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = ID_W'((int'(last_id_i) + 1 + k) % NUM_SRC);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_id_i;

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture into pending and hold registers,
// masked arbitration, IDLE/REQ/SERVICE request FSM. Option: IRQ_RR_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                 NUM_SRC   = 4,
  parameter int                 DATA_W    = 32,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
  parameter logic [NUM_SRC-1:0] MASK_RST  = '1
) (
  input logic       clk,
  input logic       rst_n,
  irq_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] set_vec, clr_vec, cap_vec;
  logic [DATA_W-1:0]  hold_q [NUM_SRC];

  state_t             state_q;
  logic               irq_req_q, busy_q;
  logic [ID_W-1:0]    irq_id_q, last_id_q;
  logic [DATA_W-1:0]  irq_data_q;

  logic               arb_valid;
  logic [ID_W-1:0]    arb_id;

  // A set coinciding with the ack-clear of the same bit wins and recaptures.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      set_vec[i] = EDGE_MASK[i] ? (bus.irq_src[i] & ~src_q[i]) : bus.irq_src[i];
    end
    if (state_q == REQ && bus.irq_ack) clr_vec[irq_id_q] = 1'b1;
    cap_vec   = set_vec & (~pending_q | clr_vec);
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= '0;
    end else begin
      src_q     <= bus.irq_src;
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cap_vec[i]) hold_q[i] <= bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  irq_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .req_i     (pending_q & mask_q),
    .last_id_i (last_id_q),
    .valid_o   (arb_valid),
    .id_o      (arb_id)
  );

  // The winner is latched on leaving IDLE, so later mask writes cannot
  // withdraw a request that is already committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      irq_id_q   <= '0;
      irq_data_q <= '0;
      last_id_q  <= ID_W'(NUM_SRC - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            irq_id_q   <= arb_id;
            irq_data_q <= hold_q[arb_id];
            irq_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            irq_req_q <= 1'b0;
            last_id_q <= irq_id_q;
            state_q   <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.irq_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          irq_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq_req   = irq_req_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.irq_data  = irq_data_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run
// against a transaction-level reference model. Honors IRQ_RR_EN.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = $clog2(NUM_SRC);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  irq_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .DATA_W    (DATA_W),
    .EDGE_MASK (4'b1111),
    .MASK_RST  (4'b1111)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [NUM_SRC-1:0]     m_pending;
  logic [NUM_SRC-1:0]     m_mask;
  logic [DATA_W-1:0]      m_hold [NUM_SRC];
  int                     m_last;
  logic [ID_W+DATA_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_pending = '0;
    m_mask    = '1;
    for (int i = 0; i < NUM_SRC; i++) m_hold[i] = '0;
    m_last = NUM_SRC - 1;
    exp_q.delete();
  endfunction

  function automatic void model_pulse(input logic [NUM_SRC-1:0] vec,
                                      input logic [NUM_SRC*DATA_W-1:0] data);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i] && !m_pending[i]) begin
        m_pending[i] = 1'b1;
        m_hold[i]    = data[i*DATA_W +: DATA_W];
      end
    end
  endfunction

  function automatic int model_winner();
    logic [NUM_SRC-1:0] elig;
    elig = m_pending & m_mask;
`ifdef IRQ_RR_EN
    for (int k = 1; k <= NUM_SRC; k++) begin
      int j;
      j = (m_last + k) % NUM_SRC;
      if (elig[j]) return j;
    end
`else
    for (int j = 0; j < NUM_SRC; j++) begin
      if (elig[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic logic [NUM_SRC*DATA_W-1:0] rand_data();
    logic [NUM_SRC*DATA_W-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i*DATA_W +: DATA_W] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic drive_idle();
    bus.irq_src    = '0;
    bus.src_data   = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack    = 1'b0;
    bus.irq_done   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] vec, input logic [NUM_SRC*DATA_W-1:0] data);
    bus.irq_src  = vec;
    bus.src_data = data;
    model_pulse(vec, data);
    @(negedge clk);
    bus.irq_src  = '0;
    bus.src_data = rand_data();
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    @(negedge clk);
    bus.mask_we    = 1'b0;
    m_mask         = m;
  endtask

  task automatic ack_done(input int svc);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    repeat (svc) @(negedge clk);
    bus.irq_done = 1'b1;
    @(negedge clk);
    bus.irq_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus.irq_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.irq_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: irq_req=%b after %0d cycles, want 1", tag, bus.irq_req, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.irq_req); end
    checks++; if (bus.irq_id !== '0) begin errors++; $display("FAIL rst_id: got %0d want 0", bus.irq_id); end
    checks++; if (bus.irq_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", bus.irq_data); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL rst_pending: got %b want 0", bus.pending); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", bus.dbg_state); end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_release_req: got %b want 0", bus.irq_req); end
  endtask

  task automatic test_edge_latency();
    logic [NUM_SRC*DATA_W-1:0] d;
    do_reset();
    d = rand_data();
    d[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    bus.irq_src  = 4'b0100;
    bus.src_data = d;
    @(negedge clk);
    bus.irq_src = '0;
    bus.irq_ack = 1'b1;  // stray ack while idle
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL lat_pending: got %b want 0100", bus.pending); end
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL lat_req_early: got %b want 0", bus.irq_req); end
    @(negedge clk);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL lat_req: got %b want 1", bus.irq_req); end
    checks++; if (bus.irq_id !== 2'd2) begin errors++; $display("FAIL lat_id: got %0d want 2", bus.irq_id); end
    checks++; if (bus.irq_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_data: got %h want deadbeef", bus.irq_data); end
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL lat_idle_ack: got %b want 0100", bus.pending); end
    bus.irq_done = 1'b1;  // done while requesting is ignored
    @(negedge clk);
    bus.irq_ack  = 1'b0;
    bus.irq_done = 1'b0;
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL lat_ack_req: got %b want 0", bus.irq_req); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL lat_ack_clear: got %b want 0000", bus.pending); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL lat_svc_busy: got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL lat_early_done: got %b want 1", bus.busy); end
    bus.irq_done = 1'b1;
    @(negedge clk);
    bus.irq_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL lat_done_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_two_sources();
    logic [NUM_SRC*DATA_W-1:0] d;
    do_reset();
    d = rand_data();
    pulse(4'b1010, d);
    wait_req("two_a");
    checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("FAIL two_id1: got %0d want 1", bus.irq_id); end
    checks++; if (bus.irq_data !== d[1*DATA_W +: DATA_W]) begin errors++; $display("FAIL two_data1: got %h want %h", bus.irq_data, d[1*DATA_W +: DATA_W]); end
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    @(negedge clk);
    bus.irq_done = 1'b1;
    @(negedge clk);
    bus.irq_done = 1'b0;
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL two_gap: got %b want 0", bus.irq_req); end
    checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL two_pending: got %b want 1000", bus.pending); end
    @(negedge clk);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL two_req3: got %b want 1", bus.irq_req); end
    checks++; if (bus.irq_id !== 2'd3) begin errors++; $display("FAIL two_id3: got %0d want 3", bus.irq_id); end
    checks++; if (bus.irq_data !== d[3*DATA_W +: DATA_W]) begin errors++; $display("FAIL two_data3: got %h want %h", bus.irq_data, d[3*DATA_W +: DATA_W]); end
    ack_done(1);
  endtask

`ifdef IRQ_RR_EN
  task automatic test_round_robin();
    int order [5];
    int w;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    pulse(4'b1111, rand_data());
    for (int s = 0; s < 5; s++) begin
      w = model_winner();
      wait_req("rr");
      checks++; if (bus.irq_id !== ID_W'(order[s])) begin errors++; $display("FAIL rr_id%0d: got %0d want %0d", s, bus.irq_id, order[s]); end
      checks++; if (bus.irq_data !== m_hold[w]) begin errors++; $display("FAIL rr_data%0d: got %h want %h", s, bus.irq_data, m_hold[w]); end
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack  = 1'b0;
      m_pending[w] = 1'b0;
      m_last       = w;
      pulse(NUM_SRC'(1) << w, rand_data());  // keep every source pending
      bus.irq_done = 1'b1;
      @(negedge clk);
      bus.irq_done = 1'b0;
    end
  endtask
`endif

  task automatic test_mask();
    logic [NUM_SRC*DATA_W-1:0] d;
    do_reset();
    write_mask(4'b1110);
    d = rand_data();
    pulse(4'b0001, d);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_noreq%0d: got %b want 0", k, bus.irq_req); end
      @(negedge clk);
    end
    checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL mask_pending: got %b want 0001", bus.pending); end
    pulse(4'b0001, rand_data());  // second edge must not overwrite the hold
    write_mask(4'b1111);
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_unmask_early: got %b want 0", bus.irq_req); end
    @(negedge clk);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL mask_unmask_req: got %b want 1", bus.irq_req); end
    checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("FAIL mask_id: got %0d want 0", bus.irq_id); end
    checks++; if (bus.irq_data !== d[DATA_W-1:0]) begin errors++; $display("FAIL mask_data: got %h want %h", bus.irq_data, d[DATA_W-1:0]); end
    write_mask(4'b0000);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL mask_committed: got %b want 1", bus.irq_req); end
    ack_done(0);
    pulse(4'b0100, rand_data());
    repeat (3) @(negedge clk);
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_all_off: got %b want 0", bus.irq_req); end
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL mask_all_pending: got %b want 0100", bus.pending); end
  endtask

  task automatic test_set_clear();
    logic [NUM_SRC*DATA_W-1:0] d, d2;
    do_reset();
    d = rand_data();
    pulse(4'b0100, d);
    wait_req("sc_a");
    checks++; if (bus.irq_data !== d[2*DATA_W +: DATA_W]) begin errors++; $display("FAIL sc_data1: got %h want %h", bus.irq_data, d[2*DATA_W +: DATA_W]); end
    d2 = rand_data();
    bus.irq_ack  = 1'b1;
    bus.irq_src  = 4'b0100;
    bus.src_data = d2;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    bus.irq_src = '0;
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL sc_pending: got %b want 0100", bus.pending); end
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL sc_req_drop: got %b want 0", bus.irq_req); end
    bus.irq_done = 1'b1;
    @(negedge clk);
    bus.irq_done = 1'b0;
    wait_req("sc_b");
    checks++; if (bus.irq_id !== 2'd2) begin errors++; $display("FAIL sc_id2: got %0d want 2", bus.irq_id); end
    checks++; if (bus.irq_data !== d2[2*DATA_W +: DATA_W]) begin errors++; $display("FAIL sc_data2: got %h want %h", bus.irq_data, d2[2*DATA_W +: DATA_W]); end
    ack_done(0);
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL sc_final: got %b want 0000", bus.pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(4'b1000, rand_data());
    wait_req("rm");
    pulse(4'b0010, rand_data());
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", bus.irq_req); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rm_pending: got %b want 0000", bus.pending); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rm_after%0d: got %b want 0", k, bus.irq_req); end
    end
  endtask

  task automatic serve_all(input string tag);
    int w;
    logic [ID_W+DATA_W-1:0] e;
    w = model_winner();
    while (w >= 0) begin
      exp_q.push_back({ID_W'(w), m_hold[w]});
      wait_req(tag);
      e = exp_q.pop_front();
      checks++; if (bus.irq_id !== e[DATA_W +: ID_W]) begin errors++; $display("FAIL %s_id: got %0d want %0d", tag, bus.irq_id, e[DATA_W +: ID_W]); end
      checks++; if (bus.irq_data !== e[DATA_W-1:0]) begin errors++; $display("FAIL %s_data: got %h want %h", tag, bus.irq_data, e[DATA_W-1:0]); end
      bus.irq_ack = 1'b1;
      @(negedge clk);
      bus.irq_ack  = 1'b0;
      m_pending[w] = 1'b0;
      m_last       = w;
      if ($urandom_range(0, 1) == 1) pulse(NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1)), rand_data());
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.irq_done = 1'b1;
      @(negedge clk);
      bus.irq_done = 1'b0;
      w = model_winner();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        write_mask(NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1)));
        serve_all("rnd_m");
      end
      pulse(NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1)), rand_data());
      serve_all("rnd");
      checks++; if (bus.pending !== m_pending) begin errors++; $display("FAIL rnd_pending%0d: got %b want %b", it, bus.pending, m_pending); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_busy%0d: got %b want 0", it, bus.busy); end
    end
    write_mask('1);
    serve_all("rnd_drain");
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL rnd_drain_pending: got %b want 0", bus.pending); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_edge_latency();
    test_two_sources();
`ifdef IRQ_RR_EN
    test_round_robin();
`endif
    test_mask();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
